// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state encodings,
// default operand width and small op-decoding helpers.
package mdu_iter_pkg;

   localparam int unsigned WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e o);
      return o[1];
   endfunction

   function automatic logic op_is_signed(input mdu_op_e o);
      return ~o[0];
   endfunction

endpackage

// File: rtl/mdu_neg.sv
// Combinational conditional two's-complement negate: result = en ? -value : value.
module mdu_neg #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] value,
   input  logic         en,
   output logic [W-1:0] result
);

   assign result = en ? (~value + 1'b1) : value;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers, a start/busy/done
// handshake and MTHI/MTLO write port. One result bit per cycle over WIDTH cycles.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   mdu_state_e         state, state_nx;
   mdu_op_e            op_in, op_q;
   logic               launch, move_ok, calc_last;
   logic               in_signed, prod_neg, rem_neg;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc, acc_nx;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quo_fixed, rem_fixed;
   logic [WIDTH:0]     msum, shifted;
   logic [WIDTH-1:0]   dsub;
   logic               ge;

   assign op_in     = mdu_op_e'(op);
   assign in_signed = op_is_signed(op_in);
   assign busy      = (state != S_IDLE);
   assign calc_last = (cnt == CW'(WIDTH - 1));

   mdu_neg #(.W(WIDTH)) u_abs_a (.value(a), .en(in_signed & a[WIDTH-1]), .result(a_mag));
   mdu_neg #(.W(WIDTH)) u_abs_b (.value(b), .en(in_signed & b[WIDTH-1]), .result(b_mag));

   mdu_neg #(.W(2*WIDTH)) u_fix_prod (.value(acc), .en(prod_neg), .result(prod_fixed));
   mdu_neg #(.W(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .en(prod_neg), .result(quo_fixed));
   mdu_neg #(.W(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .en(rem_neg), .result(rem_fixed));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      move_ok  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               launch   = 1'b1;
               state_nx = S_CALC;
            end else begin
               move_ok = 1'b1;
            end
         end
         S_CALC:  if (calc_last) state_nx = S_FIX;
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // acc holds {partial, multiplier} for mult and {remainder, dividend/quotient} for div;
   // both shift one bit per iteration so the same register serves either op.
   always_comb begin
      msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted = acc[2*WIDTH-1:WIDTH-1];
      ge      = (shifted >= {1'b0, opnd});
      dsub    = shifted[WIDTH-1:0] - opnd;
      if (op_is_div(op_q))
         acc_nx = ge ? {dsub, acc[WIDTH-2:0], 1'b1}
                     : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_nx = {msum, acc[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= OP_MULT;
         opnd     <= '0;
         acc      <= '0;
         cnt      <= '0;
         prod_neg <= 1'b0;
         rem_neg  <= 1'b0;
      end else if (launch) begin
         op_q     <= op_in;
         opnd     <= b_mag;
         acc      <= {{WIDTH{1'b0}}, a_mag};
         cnt      <= '0;
         prod_neg <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         rem_neg  <= in_signed & a[WIDTH-1];
      end else if (state == S_CALC) begin
         acc <= acc_nx;
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= (state == S_FIX);
         if (state == S_FIX) begin
            if (op_is_div(op_q)) begin
               hi <= rem_fixed;
               lo <= quo_fixed;
            end else begin
               {hi, lo} <= prod_fixed;
            end
         end else if (move_ok) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: latency, arithmetic corners, handshake,
// HI/LO moves and asynchronous reset.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        mthi, mtlo;
   logic [31:0] wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int fails  = 0;

   mdu_iter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0;
   endtask

   // n = edges after launch until done seen (bounded at 40); nb = cycles busy observed
   task automatic wait_done(output int n, output int nb);
      n  = 0;
      nb = busy ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (busy) nb++;
         if (done) break;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, hi, lo} !== 66'b0) begin
         fails++;
         $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
      end
   endtask

   task automatic test_multu();
      int n, nb;
      launch(2'b01, 32'hFFFF_FFFF, 32'h2);
      wait_done(n, nb);
      checks++;
      if (n !== 33) begin fails++; $display("FAIL multu_latency: got %0d, required 33", n); end
      checks++;
      if (nb !== 33) begin fails++; $display("FAIL multu_busy_cycles: got %0d, required 33", nb); end
      checks++;
      if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
         fails++; $display("FAIL multu_result: got %h_%h, required 00000001_fffffffe", hi, lo);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_mult_signed();
      int n, nb;
      launch(2'b00, 32'hFFFF_FFFD, 32'd7);
      wait_done(n, nb);
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         fails++; $display("FAIL mult_neg: got %h_%h, required ffffffff_ffffffeb", hi, lo);
      end
   endtask

   task automatic test_div();
      int n, nb;
      launch(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done(n, nb);
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         fails++; $display("FAIL div_neg: lo=%h hi=%h, required lo=fffffffd hi=ffffffff", lo, hi);
      end
      launch(2'b11, 32'd7, 32'd0);
      wait_done(n, nb);
      checks++;
      if (n !== 33) begin fails++; $display("FAIL divzero_latency: got %0d, required 33", n); end
      checks++;
      if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
         fails++; $display("FAIL divu_zero: lo=%h hi=%h, required lo=ffffffff hi=00000007", lo, hi);
      end
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n, nb);
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
         fails++; $display("FAIL div_overflow: lo=%h hi=%h, required lo=80000000 hi=00000000", lo, hi);
      end
   endtask

   task automatic test_start_while_busy();
      int n, nb, extra;
      launch(2'b01, 32'd3, 32'd5);
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
         fails++; $display("FAIL hold_during_calc: lo=%h hi=%h, required lo=80000000 hi=00000000", lo, hi);
      end
      start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
      tick();
      start = 1'b0;
      wait_done(n, nb);
      checks++;
      if (n + 10 !== 33) begin fails++; $display("FAIL busy_start_latency: got %0d, required 33", n + 10); end
      checks++;
      if (lo !== 32'd15 || hi !== 32'd0) begin
         fails++; $display("FAIL busy_start_result: lo=%h hi=%h, required lo=0000000f hi=00000000", lo, hi);
      end
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done || busy) extra++;
      end
      checks++;
      if (extra !== 0) begin fails++; $display("FAIL no_second_op: got %0d active cycles, required 0", extra); end
   endtask

   task automatic test_moves();
      int n, nb;
      mthi = 1'b1; wdata = 32'hDEAD_BEEF;
      launch(2'b01, 32'd2, 32'd3);
      mthi = 1'b0;
      checks++;
      if (hi !== 32'd0) begin fails++; $display("FAIL move_vs_start: hi=%h, required 00000000", hi); end
      wait_done(n, nb);
      checks++;
      if (lo !== 32'd6 || hi !== 32'd0) begin
         fails++; $display("FAIL move_op_result: lo=%h hi=%h, required lo=00000006 hi=00000000", lo, hi);
      end
      mtlo = 1'b1; wdata = 32'd5;
      tick();
      mtlo = 1'b0;
      checks++;
      if (lo !== 32'd5 || hi !== 32'd0) begin
         fails++; $display("FAIL mtlo: lo=%h hi=%h, required lo=00000005 hi=00000000", lo, hi);
      end
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      checks++;
      if (lo !== 32'hA5A5_5A5A || hi !== 32'hA5A5_5A5A) begin
         fails++; $display("FAIL mthi_mtlo_both: lo=%h hi=%h, required a5a55a5a both", lo, hi);
      end
   endtask

   task automatic test_async_reset();
      int n, nb;
      launch(2'b10, 32'hFFFF_FFF9, 32'd2);
      for (int i = 0; i < 14; i++) tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, hi, lo} !== 66'b0) begin
         fails++;
         $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
      end
      #2 rst = 1'b0;
      tick();
      launch(2'b01, 32'd3, 32'd4);
      wait_done(n, nb);
      checks++;
      if (n !== 33) begin fails++; $display("FAIL post_reset_latency: got %0d, required 33", n); end
      checks++;
      if (lo !== 32'd12 || hi !== 32'd0) begin
         fails++; $display("FAIL post_reset_mult: lo=%h hi=%h, required lo=0000000c hi=00000000", lo, hi);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      #12;
      test_reset();
      rst = 1'b0;
      tick();
      test_multu();
      test_mult_signed();
      test_div();
      test_start_while_busy();
      test_moves();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
